// File: rtl/line_mem_responder_pkg.sv
// line_mem_responder_pkg: shared line type, memory op and responder state encodings
package line_mem_responder_pkg;
    typedef logic [127:0] lc3b_line;
    localparam int LC3B_LINE_OFFSET_W = 4;
    typedef enum logic {MEM_RD, MEM_WR} lc3b_mem_op;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} resp_state_e;
endpackage

// File: rtl/line_mem_array.sv
// line_mem_array: line store with synchronous write and combinational read
module line_mem_array
    import line_mem_responder_pkg::*;
#(
    parameter int INDEX_W = 12
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_windex,
    input  lc3b_line           i_wdata,
    input  logic [INDEX_W-1:0] i_rindex,
    output lc3b_line           o_rdata
);
    lc3b_line r_mem [0:(1<<INDEX_W)-1];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_windex] <= i_wdata;
    end
    assign o_rdata = r_mem[i_rindex];
endmodule

// File: rtl/line_mem_responder.sv
// line_mem_responder: fixed-latency full-line read/write responder with saturating perf counters
module line_mem_responder
    import line_mem_responder_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int INDEX_W = 12,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [15:0]      mem_address,
    input  lc3b_line         mem_wdata,
    output lc3b_line         mem_rdata,
    output logic             mem_resp,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);
    resp_state_e        r_state;
    logic [3:0]         r_cnt;
    logic [INDEX_W-1:0] r_index;
    lc3b_mem_op         r_op;
    lc3b_line           r_wdata;
    logic               r_resp;
    lc3b_line           r_rdata;
    logic [CNT_W-1:0]   r_rd_count;
    logic [CNT_W-1:0]   r_wr_count;
    logic               w_req;
    logic               w_req_live;
    logic               w_enter_resp;
    logic               w_we;
    logic               w_unused_offset;
    logic [INDEX_W-1:0] w_in_index;
    logic [INDEX_W-1:0] w_rindex;
    lc3b_mem_op         w_in_op;
    lc3b_mem_op         w_op;
    lc3b_line           w_line;

    assign w_req           = mem_read | mem_write;
    assign w_in_index      = mem_address[LC3B_LINE_OFFSET_W +: INDEX_W];
    assign w_unused_offset = ^mem_address[LC3B_LINE_OFFSET_W-1:0];
    assign w_in_op         = mem_write ? MEM_WR : MEM_RD;
    assign w_req_live      = (r_op == MEM_WR) ? mem_write : mem_read;
    // The read port follows the incoming index in IDLE so LATENCY==1 can load rdata on accept
    assign w_op            = (r_state == IDLE) ? w_in_op : r_op;
    assign w_rindex        = (r_state == IDLE) ? w_in_index : r_index;
    assign w_enter_resp    = (r_state == IDLE) ? (w_req && (LATENCY == 1))
                                               : (r_state == BUSY && w_req_live && r_cnt == 4'd1);
    assign w_we            = (r_state == RESP) && (r_op == MEM_WR) && !rst;

    line_mem_array #(.INDEX_W(INDEX_W)) u_array (
        .clk      (clk),
        .i_we     (w_we),
        .i_windex (r_index),
        .i_wdata  (r_wdata),
        .i_rindex (w_rindex),
        .o_rdata  (w_line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_resp     <= 1'b0;
            r_rdata    <= '0;
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            r_resp <= w_enter_resp;
            if (w_enter_resp && w_op == MEM_RD) r_rdata <= w_line;
            case (r_state)
                IDLE: if (w_req) begin
                    r_index <= w_in_index;
                    r_op    <= w_in_op;
                    r_wdata <= mem_wdata;
                    r_cnt   <= 4'(LATENCY - 1);
                    r_state <= (LATENCY == 1) ? RESP : BUSY;
                end
                BUSY: begin
                    r_cnt   <= r_cnt - 4'd1;
                    r_state <= !w_req_live ? IDLE : (r_cnt == 4'd1 ? RESP : BUSY);
                end
                RESP: begin
                    r_state <= IDLE;
                    if (r_op == MEM_RD && r_rd_count != '1) r_rd_count <= r_rd_count + 1'b1;
                    if (r_op == MEM_WR && r_wr_count != '1) r_wr_count <= r_wr_count + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_resp  = r_resp;
    assign mem_rdata = r_rdata;
    assign rd_count  = r_rd_count;
    assign wr_count  = r_wr_count;
endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: directed + randomized checks against a line-granular reference model
module tb_line_mem_responder;
    import line_mem_responder_pkg::*;
    localparam int LAT   = 4;
    localparam int IW    = 12;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [15:0]   mem_address = '0;
    lc3b_line      mem_wdata = '0;
    lc3b_line      mem_rdata;
    logic          mem_resp;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] wr_count;

    int       n_chk = 0;
    int       n_err = 0;
    lc3b_line mem_m [int];
    lc3b_line rdata_m = '0;
    int       rd_m = 0;
    int       wr_m = 0;
    int       pool [8];

    line_mem_responder #(.LATENCY(LAT), .INDEX_W(IW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp),
        .rd_count    (rd_count),
        .wr_count    (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic lc3b_line rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic check_state(input string tag);
        check({tag, "_rd_count"}, 128'(rd_count), 128'(rd_m));
        check({tag, "_wr_count"}, 128'(wr_count), 128'(wr_m));
        check({tag, "_rdata"}, mem_rdata, rdata_m);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd_m = 0;
        wr_m = 0;
        rdata_m = '0;
    endtask

    // Full transaction: request in cycle 0, expect the pulse exactly LAT cycles later
    task automatic xact(input logic rd, input logic wr, input logic [15:0] addr, input lc3b_line data);
        int lat;
        int idx;
        idx = int'(addr) / 16;
        @(negedge clk);
        mem_read = rd;
        mem_write = wr;
        mem_address = addr;
        mem_wdata = data;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!mem_resp) begin
                mem_address = 16'($urandom);
                mem_wdata = rnd_line();
            end
        end while (!mem_resp && lat < 20);
        check("latency", 128'(lat), 128'(LAT));
        mem_read = 1'b0;
        mem_write = 1'b0;
        if (wr) begin
            mem_m[idx] = data;
            wr_m = sat(wr_m);
        end else begin
            rdata_m = mem_m.exists(idx) ? mem_m[idx] : '0;
            rd_m = sat(rd_m);
        end
        check("resp_rdata", mem_rdata, rdata_m);
        @(negedge clk);
        check("resp_low", 128'(mem_resp), 128'(0));
        check_state("post");
    endtask

    // Request dropped at negedge of cycle drop_at (inside BUSY): nothing may complete
    task automatic abort_xact(input logic rd, input logic wr, input logic [15:0] addr, input int drop_at);
        int seen;
        seen = 0;
        @(negedge clk);
        mem_read = rd;
        mem_write = wr;
        mem_address = addr;
        mem_wdata = rnd_line();
        repeat (drop_at) begin
            @(negedge clk);
            seen += int'(mem_resp);
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        repeat (LAT + 2) begin
            @(negedge clk);
            seen += int'(mem_resp);
        end
        check("abort_no_resp", 128'(seen), 128'(0));
        check_state("abort");
    endtask

    // Reset lands in the cycle before RESP of a write: no pulse, no commit, counters cleared
    task automatic reset_in_write(input logic [15:0] addr);
        int seen;
        seen = 0;
        @(negedge clk);
        mem_write = 1'b1;
        mem_address = addr;
        mem_wdata = rnd_line();
        repeat (LAT - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        seen += int'(mem_resp);
        rst = 1'b0;
        mem_write = 1'b0;
        rd_m = 0;
        wr_m = 0;
        rdata_m = '0;
        repeat (3) begin
            @(negedge clk);
            seen += int'(mem_resp);
        end
        check("rst_no_resp", 128'(seen), 128'(0));
        check_state("rst");
    endtask

    initial begin
        lc3b_line pre;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_resp", 128'(mem_resp), 128'(0));
        check_state("reset");

        pre = rnd_line();
        xact(1'b0, 1'b1, 16'h0040, pre);
        xact(1'b0, 1'b1, 16'h5670, rnd_line());
        xact(1'b1, 1'b0, 16'h0040, '0);
        check("preload_line4", mem_rdata, pre);

        do_reset();
        xact(1'b0, 1'b1, 16'h0040, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
        xact(1'b1, 1'b0, 16'h004E, '0);
        check("raw_same_line", mem_rdata, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);

        do_reset();
        xact(1'b0, 1'b1, 16'h1230, rnd_line());
        xact(1'b1, 1'b0, 16'h5670, '0);

        do_reset();
        xact(1'b1, 1'b1, 16'h0100, rnd_line());
        check("both_high_wr", 128'(wr_count), 128'(1));
        check("both_high_rd", 128'(rd_count), 128'(0));
        abort_xact(1'b0, 1'b1, 16'h0100, 2);
        xact(1'b1, 1'b0, 16'h0100, '0);
        reset_in_write(16'h0100);
        xact(1'b1, 1'b0, 16'h0108, '0);

        for (int i = 0; i < 8; i++) pool[i] = int'($urandom_range(0, (1 << IW) - 1));
        for (int t = 0; t < 70; t++) begin
            int kind;
            int idx;
            logic [15:0] a;
            kind = int'($urandom_range(0, 9));
            idx = pool[$urandom_range(0, 7)];
            a = 16'(idx * 16 + int'($urandom_range(0, 15)));
            if (kind < 2)
                abort_xact(kind == 0, kind == 1, a, int'($urandom_range(1, LAT - 1)));
            else if (kind < 5 || !mem_m.exists(idx))
                xact(kind == 4, 1'b1, a, rnd_line());
            else
                xact(1'b1, 1'b0, a, '0);
        end
        check("sat_rd", 128'(rd_count), 128'(rd_m));
        check("sat_wr", 128'(wr_count), 128'(wr_m));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
